abc_vector_sequencer: RTL
=========================

Name: abc_vector_sequencer

Overview:
- Upstream stimulus stage for the 3-input combinational `silly` block (inputs a, b, c; outputs y, sum).
- On start, steps an 8-entry vector sequence onto a/b/c and holds each vector for HOLD_CYCLES clocks.
- Captures the returned y/sum at the end of each hold window into 8-bit result logs.
- Replaces hand-written `#delay` stimulus with a synthesizable, self-timed driver usable on board and in simulation.

Parameters:
- HOLD_CYCLES, 1, clocks each vector is held before sampling (legal range 1..255).
- LOOP, 0, 1 = restart the sequence automatically after vector 7 instead of entering DONE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- mode  in  1  0 = table order, 1 = binary count; latched on the accepted start.
- abort  in  1  return to IDLE at the next edge; logs are kept.
- y_in  in  1  y output of the driven block.
- sum_in  in  1  sum output of the driven block.
- a  out  1  stimulus bit a.
- b  out  1  stimulus bit b.
- c  out  1  stimulus bit c.
- valid  out  1  high while a/b/c carry a sequence vector (APPLY state).
- busy  out  1  high in APPLY.
- done  out  1  high in DONE; held until start, abort or reset.
- vec_idx  out  3  index of the vector currently applied.
- y_log  out  8  bit k = y_in captured for vector k.
- sum_log  out  8  bit k = sum_in captured for vector k.

Behaviour:
- Clocking and reset: single clock domain, one clock; reset is synchronous and active-high. All outputs and state are registered.
- Reset values:
  - state = IDLE.
  - a, b, c, valid, busy, done = 0.
  - vec_idx = 0, hold counter = 0.
  - y_log, sum_log = 8'h00.
  - Reset mid-run aborts the run and clears the logs.
- Table order ({a,b,c} for k = 0..7): 111, 101, 110, 010, 001, 000, 100, 011.
- Binary order: {a,b,c} = k.
- IDLE:
  - start=1 at an edge: latch mode, clear both logs, k=0, drive vector 0, hold counter = 0, go to APPLY.
- APPLY, each edge:
  - If hold counter < HOLD_CYCLES-1: increment the counter.
  - If hold counter = HOLD_CYCLES-1: capture y_log[k] <= y_in and sum_log[k] <= sum_in, reset the counter.
    - If k < 7: k <= k+1 and drive the next vector.
    - If k = 7 and LOOP=0: go to DONE. a/b/c keep the last vector, valid=0.
    - If k = 7 and LOOP=1: k <= 0, drive vector 0. Logs are overwritten in place, not cleared.
- Capture timing: each vector is visible for exactly HOLD_CYCLES cycles. The capture edge is the last edge of that window, so the block under drive must settle within HOLD_CYCLES clocks.
- Run length (LOOP=0): done rises exactly 8*HOLD_CYCLES edges after the start edge.
- start while in APPLY is ignored.
- start in DONE behaves as in IDLE: logs cleared, new run begins.
- abort has priority over capture:
  - Next edge goes to IDLE with a/b/c, valid, busy, done = 0.
  - The partial logs are retained.
  - The pending capture on that edge is not performed.
- reset has priority over abort and start.
- mode changes after the start edge have no effect until the next run.

Decomposition:
- Package abc_seq_pkg holds:
  - the state enum (IDLE, APPLY, DONE);
  - the 8x3 table-order constant;
  - NUM_VEC = 8;
  - the hold-counter width derived from HOLD_CYCLES.
- One natural sub-module, abc_hold_timer: the hold counter, producing a one-cycle `last` strobe, with clear/enable inputs.

Test Plan:
- Reference model for all directed tests: y = a&b, sum = a^b^c.
- Table order, HOLD_CYCLES=1, mode=0, pulse start:
  - a/b/c step 111, 101, …, 011 on consecutive cycles.
  - done rises 8 edges after the start edge.
  - sum_log = 8'h59, y_log = 8'h05.
- Binary order, HOLD_CYCLES=3, mode=1:
  - Each vector is held 3 cycles; done rises 24 edges after start.
  - sum_log = 8'h96, y_log = 8'hC0.
- Abort mid-run: abort at the edge where vec_idx=4 would be captured (HOLD_CYCLES=1, mode=0):
  - Next cycle: IDLE, valid=0, done=0.
  - sum_log[3:0] = 4'h9, bit 4 not written (0).
- Reset mid-run (vec_idx=5): asserted one cycle:
  - All outputs are 0 and both logs are 8'h00 on the following cycle.
  - A new start then completes normally.
- start during APPLY, and start while done=1:
  - The first is ignored; vec_idx continues uninterrupted.
  - The second clears the logs, drops done and restarts at vector 0.
- LOOP=1, HOLD_CYCLES=1:
  - After vector 7, vector 0 reappears on the next cycle; done never asserts.
  - Logs remain 8'h59 / 8'h05 across two full loops.

Source files
------------

// File: rtl/abc_seq_pkg.sv
// Shared definitions for the a/b/c vector sequencer: state encoding,
// the fixed table-order stimulus, and the helpers that size the hold
// counter and pick the vector for a given index.
package abc_seq_pkg;

   // Sequencer states: waiting, driving vectors, finished with results held
   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      DONE
   } seq_state_t;

   localparam int NUM_VEC = 8;

   // Table order, element k is {a,b,c} for vector k (element 0 is the LSBs)
   localparam logic [NUM_VEC-1:0][2:0] TABLE_ORDER = {
      3'b011, 3'b100, 3'b000, 3'b001,
      3'b010, 3'b110, 3'b101, 3'b111
   };

   // The hold counter runs 0..holdCycles-1, so it never needs fewer than one bit
   function automatic int holdWidth(input int holdCycles);
      return (holdCycles > 1) ? $clog2(holdCycles) : 1;
   endfunction

   // Binary mode drives the index itself; table mode looks the vector up
   function automatic logic [2:0] vectorFor(input logic binaryMode, input logic [2:0] idx);
      if (binaryMode) begin
         return idx;
      end
      return TABLE_ORDER[idx];
   endfunction

endpackage

// File: rtl/abc_hold_timer.sv
// Counts how long the current vector has been on the a/b/c pins and
// flags the last cycle of the hold window so the sequencer knows when
// to sample the driven block and advance.
module abc_hold_timer
   import abc_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic last
);

   localparam int CW = holdWidth(HOLD_CYCLES);
   localparam logic [CW-1:0] LAST_COUNT = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] count;

   // Clear parks the counter at zero so every new vector starts a fresh
   // window; while enabled it wraps back to zero after the last count.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == LAST_COUNT) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   // The strobe is only meaningful while the window is actually running,
   // so it is gated by enable to make a disabled timer never fire.
   assign last = enable && (count == LAST_COUNT);

endmodule

// File: rtl/abc_vector_sequencer.sv
// Self-timed stimulus driver for the 3-input `silly` block. On start it
// walks eight a/b/c vectors (table or binary order), holds each one for
// HOLD_CYCLES clocks, and records the returned y/sum into 8-bit logs.
module abc_vector_sequencer
   import abc_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 1,
   parameter bit LOOP        = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       mode,
   input  logic       abort,
   input  logic       y_in,
   input  logic       sum_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       valid,
   output logic       busy,
   output logic       done,
   output logic [2:0] vec_idx,
   output logic [7:0] y_log,
   output logic [7:0] sum_log
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);

   seq_state_t state;
   logic       modeLatched;
   logic       holdLast;
   logic       timerClear;
   logic       timerEnable;

   // The window only runs in APPLY; an abort stops it on the same edge so
   // the capture that would have happened there is suppressed.
   assign timerClear  = (state != APPLY) || abort;
   assign timerEnable = (state == APPLY) && !abort;

   abc_hold_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) holdTimer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timerClear),
      .enable (timerEnable),
      .last   (holdLast)
   );

   // Main sequencer. Reset beats abort, abort beats everything else. A
   // start is only honoured from IDLE or DONE and latches the ordering
   // mode for the whole run. At the end of each hold window the driven
   // block's outputs are logged for the current vector, then the next
   // vector is put out, the sequence wraps (LOOP) or the run finishes
   // with the last vector left on the pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         modeLatched <= 1'b0;
         {a, b, c}   <= 3'b000;
         valid       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         vec_idx     <= '0;
         y_log       <= '0;
         sum_log     <= '0;
      end else if (abort) begin
         state     <= IDLE;
         {a, b, c} <= 3'b000;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         vec_idx   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= APPLY;
                  modeLatched <= mode;
                  y_log       <= '0;
                  sum_log     <= '0;
                  vec_idx     <= '0;
                  {a, b, c}   <= vectorFor(mode, 3'd0);
                  valid       <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
               end
            end
            APPLY: begin
               if (holdLast) begin
                  y_log[vec_idx]   <= y_in;
                  sum_log[vec_idx] <= sum_in;
                  if (vec_idx != LAST_IDX) begin
                     vec_idx   <= vec_idx + 3'd1;
                     {a, b, c} <= vectorFor(modeLatched, vec_idx + 3'd1);
                  end else if (LOOP) begin
                     vec_idx   <= '0;
                     {a, b, c} <= vectorFor(modeLatched, 3'd0);
                  end else begin
                     state <= DONE;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
